// File: rtl/min_hold_pkg.sv
// Shared types and helpers for the minimum-hold output driver.
package min_hold_pkg;

  typedef enum logic {IDLE, HOLD} hold_state_t;

  // Number of clock cycles an output level must be held. Never less than one.
  function automatic int calc_hold_cycles(input int clock_period_ns, input int hold_period_ns);
    int cycles;
    cycles = hold_period_ns / clock_period_ns;
    return (cycles < 1) ? 1 : cycles;
  endfunction

endpackage

// File: rtl/min_hold_channel.sv
// One output channel: forwards a level change on the next edge, then freezes
// the output for HoldCycles cycles. During the window only the request seen at
// the expiry edge matters; absorbed requests are flagged on Dropped.
module min_hold_channel
  import min_hold_pkg::*;
#(
  parameter int   HoldCycles = 5,
  parameter int   CountWidth = 3,
  parameter logic ResetLevel = 1'b1
) (
  input  logic Clock,
  input  logic nReset,
  input  logic I,
  output logic O,
  output logic Busy,
  output logic Dropped
);

  localparam logic [CountWidth-1:0] ReloadValue = CountWidth'(HoldCycles - 1);

  hold_state_t           state_q, state_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  seen_q, seen_d;
  logic                  o_q, o_d;
  logic                  busy_q, busy_d;
  logic                  dropped_q, dropped_d;

  // State register: asynchronous reset aborts any window in progress.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      seen_q    <= 1'b0;
      o_q       <= ResetLevel;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      seen_q    <= seen_d;
      o_q       <= o_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
    end
  end

  // Next-state logic: start, extend, or close the hold window.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    seen_d    = seen_q;
    o_d       = o_q;
    dropped_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (I != o_q) begin
          o_d     = I;
          count_d = ReloadValue;
          seen_d  = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (count_q != '0) begin
          // Output frozen; remember that someone asked for a change.
          count_d = count_q - 1'b1;
          if (I != o_q) begin
            seen_d = 1'b1;
          end
        end else if (I != o_q) begin
          // Expiry with a pending level: apply it and hold it in turn.
          o_d     = I;
          count_d = ReloadValue;
          seen_d  = 1'b0;
        end else begin
          // Expiry with no pending level: report any absorbed request.
          dropped_d = seen_q;
          seen_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == HOLD);
  end

  // Outputs come straight from flops.
  always_comb begin
    O       = o_q;
    Busy    = busy_q;
    Dropped = dropped_q;
  end

endmodule

// File: rtl/min_hold_driver.sv
// Multi-channel minimum-hold driver for slow external loads. Channels are
// fully independent copies of min_hold_channel.
module min_hold_driver
  import min_hold_pkg::*;
#(
  parameter int               Size           = 3,
  parameter int               ClockPeriod_ns = 20,
  parameter int               HoldPeriod_ns  = 500_000,
  parameter logic [Size-1:0]  ResetValue     = '1
) (
  input  logic            Clock,
  input  logic            nReset,
  input  logic [Size-1:0] I,
  output logic [Size-1:0] O,
  output logic [Size-1:0] Busy,
  output logic [Size-1:0] Dropped
);

  localparam int HoldCycles = calc_hold_cycles(ClockPeriod_ns, HoldPeriod_ns);
  localparam int CountWidth = $clog2(HoldCycles + 1);

  // One independent hold channel per output bit.
  for (genvar gi = 0; gi < Size; gi++) begin : g_chan
    min_hold_channel #(
      .HoldCycles (HoldCycles),
      .CountWidth (CountWidth),
      .ResetLevel (ResetValue[gi])
    ) u_chan (
      .Clock   (Clock),
      .nReset  (nReset),
      .I       (I[gi]),
      .O       (O[gi]),
      .Busy    (Busy[gi]),
      .Dropped (Dropped[gi])
    );
  end

endmodule
